// File: rtl/pcie_msg_pkg.sv
// Shared types for the PCIe message assembler: fragment types, header layout,
// error codes and FSM state encoding.
package pcie_msg_pkg;

  // Fragment types carried in header bits [127:126]
  localparam logic [1:0] FT_M  = 2'b00;
  localparam logic [1:0] FT_L  = 2'b01;
  localparam logic [1:0] FT_S  = 2'b10;
  localparam logic [1:0] FT_SG = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Header beat layout in wdata[127:0], MSB first
  typedef struct packed {
    logic [1:0]   ftype;
    logic [1:0]   sn;
    logic [3:0]   tag;
    logic [119:0] tlp;
  } msg_hdr_t;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_BAD_TAG      = 3'd1,
    ERR_BAD_S_SN     = 3'd2,
    ERR_SEQ          = 3'd3,
    ERR_OVERFLOW     = 3'd4,
    ERR_LEN_MISMATCH = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CPL     = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/pcie_msg_ctx_table.sv
// Per-tag assembly context: active flag, expected sequence number and write
// pointer. One combinational read port and one whole-entry update port.
module pcie_msg_ctx_table #(
  parameter int NUM_TAGS = 15,
  parameter int PTR_W    = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       rd_tag_i,
  output logic             rd_active_o,
  output logic [1:0]       rd_sn_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  input  logic             upd_en_i,
  input  logic [3:0]       upd_tag_i,
  input  logic             upd_active_i,
  input  logic [1:0]       upd_sn_i,
  input  logic [PTR_W-1:0] upd_ptr_i
);

  logic [NUM_TAGS-1:0]            active_q;
  logic [NUM_TAGS-1:0][1:0]       sn_q;
  logic [NUM_TAGS-1:0][PTR_W-1:0] ptr_q;

  // Entry update; tags outside the table match nothing and are dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= '0;
      sn_q     <= '0;
      ptr_q    <= '0;
    end else if (upd_en_i) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (upd_tag_i == 4'(i)) begin
          active_q[i] <= upd_active_i;
          sn_q[i]     <= upd_sn_i;
          ptr_q[i]    <= upd_ptr_i;
        end
      end
    end
  end

  // Read mux; an out-of-range tag reads as an empty, inactive context
  always_comb begin
    rd_active_o = 1'b0;
    rd_sn_o     = '0;
    rd_ptr_o    = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (rd_tag_i == 4'(i)) begin
        rd_active_o = active_q[i];
        rd_sn_o     = sn_q[i];
        rd_ptr_o    = ptr_q[i];
      end
    end
  end

endmodule

// File: rtl/pcie_msg_assembler.sv
// Assembles fragmented PCIe messages written over an AXI write slave into
// per-tag SRAM regions, reporting protocol errors and completed messages.
module pcie_msg_assembler
  import pcie_msg_pkg::*;
#(
  parameter int DATA_W         = 256,
  parameter int NUM_TAGS       = 15,
  parameter int MSG_BEATS_LOG2 = 6,
  parameter int LEN_W          = 8,
  localparam int SRAM_AW       = 4 + MSG_BEATS_LOG2,
  localparam int PTR_W         = MSG_BEATS_LOG2 + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               axi_awvalid,
  output logic               axi_awready,
  input  logic [63:0]        axi_awaddr,
  input  logic [LEN_W-1:0]   axi_awlen,
  input  logic               axi_wvalid,
  output logic               axi_wready,
  input  logic [DATA_W-1:0]  axi_wdata,
  input  logic               axi_wlast,
  output logic               axi_bvalid,
  input  logic               axi_bready,
  output logic [1:0]         axi_bresp,
  output logic               sram_wen,
  output logic [SRAM_AW-1:0] sram_waddr,
  output logic [DATA_W-1:0]  sram_wdata,
  output logic               cpl_valid,
  input  logic               cpl_ready,
  output logic [3:0]         cpl_tag,
  output logic [PTR_W-1:0]   cpl_len,
  output logic [127:0]       cpl_header,
  output logic               err_valid,
  output logic [2:0]         err_code
);

  localparam logic [4:0] NT5 = 5'(NUM_TAGS);

  state_e               state_q, state_d;
  logic                 init_q;
  logic [LEN_W-1:0]     awlen_q, awlen_d;
  logic [LEN_W:0]       cnt_q, cnt_d;
  msg_hdr_t             hdr_q, hdr_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 err_valid_q, err_valid_d;
  err_code_e            err_code_q, err_code_d;
  logic [3:0]           cpl_tag_q, cpl_tag_d;
  logic [PTR_W-1:0]     cpl_len_q, cpl_len_d;
  logic [127:0]         cpl_hdr_q, cpl_hdr_d;
  logic                 sram_wen_q, sram_wen_d;
  logic [SRAM_AW-1:0]   sram_waddr_q, sram_waddr_d;
  logic [DATA_W-1:0]    sram_wdata_q, sram_wdata_d;

  logic [3:0]           rd_tag;
  logic                 rd_active;
  logic [1:0]           rd_sn;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 upd_en;
  logic [3:0]           upd_tag;
  logic                 upd_active;
  logic [1:0]           upd_sn;
  logic [PTR_W-1:0]     upd_ptr;

  msg_hdr_t             in_hdr, cur_hdr;
  logic [PTR_W-1:0]     cur_ptr;
  logic [LEN_W:0]       cur_cnt;
  logic                 end_fire;
  logic                 tag_ok_in;
  logic                 w_hs;
  err_code_e            hdr_err;

  // Placement is purely tag-based, so the AXI address is not needed
  logic unused_awaddr;
  assign unused_awaddr = ^axi_awaddr;

  assign in_hdr = msg_hdr_t'(axi_wdata[127:0]);
  assign rd_tag = in_hdr.tag;
  assign w_hs   = axi_wvalid && axi_wready;

  pcie_msg_ctx_table #(
    .NUM_TAGS (NUM_TAGS),
    .PTR_W    (PTR_W)
  ) u_ctx (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_tag_i     (rd_tag),
    .rd_active_o  (rd_active),
    .rd_sn_o      (rd_sn),
    .rd_ptr_o     (rd_ptr),
    .upd_en_i     (upd_en),
    .upd_tag_i    (upd_tag),
    .upd_active_i (upd_active),
    .upd_sn_i     (upd_sn),
    .upd_ptr_i    (upd_ptr)
  );

  // State register; init_q keeps awready low until the first cycle out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  // Header checks against the addressed context, evaluated on the live beat
  always_comb begin
    tag_ok_in = {1'b0, in_hdr.tag} < NT5;
    hdr_err   = ERR_NONE;
    if (!tag_ok_in)
      hdr_err = ERR_BAD_TAG;
    else if (in_hdr.ftype == FT_S && in_hdr.sn != 2'd0)
      hdr_err = ERR_BAD_S_SN;
    else if ((in_hdr.ftype == FT_M || in_hdr.ftype == FT_L) &&
             (!rd_active || in_hdr.sn != rd_sn))
      hdr_err = ERR_SEQ;
  end

  // Next-state and datapath next values; fragment end is resolved in one place
  always_comb begin
    state_d      = state_q;
    awlen_d      = awlen_q;
    hdr_d        = hdr_q;
    bresp_d      = bresp_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
    cpl_tag_d    = cpl_tag_q;
    cpl_len_d    = cpl_len_q;
    cpl_hdr_d    = cpl_hdr_q;
    sram_wen_d   = 1'b0;
    sram_waddr_d = sram_waddr_q;
    sram_wdata_d = sram_wdata_q;
    upd_en       = 1'b0;
    upd_tag      = hdr_q.tag;
    upd_active   = 1'b0;
    upd_sn       = 2'd0;
    upd_ptr      = '0;
    cur_hdr      = hdr_q;
    cur_ptr      = ptr_q;
    cur_cnt      = cnt_q;
    end_fire     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (axi_awvalid && axi_awready) begin
          awlen_d = axi_awlen;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_hs) begin
          hdr_d = in_hdr;
          if (hdr_err != ERR_NONE) begin
            err_valid_d = 1'b1;
            err_code_d  = hdr_err;
            bresp_d     = RESP_SLVERR;
            upd_en      = tag_ok_in;
            upd_tag     = in_hdr.tag;
            state_d     = axi_wlast ? ST_RESP : ST_DRAIN;
          end else begin
            cur_hdr = in_hdr;
            cur_cnt = (LEN_W+1)'(1);
            cur_ptr = (in_hdr.ftype == FT_S || in_hdr.ftype == FT_SG) ? '0 : rd_ptr;
            if (axi_wlast) end_fire = 1'b1;
            else           state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_hs) begin
          cur_cnt = cnt_q + 1'b1;
          // ptr MSB set means the region is full and this beat has nowhere to go
          if (ptr_q[PTR_W-1]) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_OVERFLOW;
            bresp_d     = RESP_SLVERR;
            upd_en      = 1'b1;
            state_d     = axi_wlast ? ST_RESP : ST_DRAIN;
          end else begin
            sram_wen_d   = 1'b1;
            sram_waddr_d = {hdr_q.tag, ptr_q[MSG_BEATS_LOG2-1:0]};
            sram_wdata_d = axi_wdata;
            cur_ptr      = ptr_q + 1'b1;
            if (axi_wlast) end_fire = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_hs && axi_wlast) state_d = ST_RESP;
      end
      ST_CPL: begin
        if (cpl_ready) begin
          upd_en  = 1'b1;
          upd_tag = cpl_tag_q;
          bresp_d = RESP_OKAY;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (axi_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_fire) begin
      upd_en  = 1'b1;
      upd_tag = cur_hdr.tag;
      if (cur_cnt != {1'b0, awlen_q} + 1'b1) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_LEN_MISMATCH;
        bresp_d     = RESP_SLVERR;
        state_d     = ST_RESP;
      end else if (cur_hdr.ftype == FT_S || cur_hdr.ftype == FT_M) begin
        upd_active = 1'b1;
        upd_sn     = cur_hdr.sn + 2'd1;
        upd_ptr    = cur_ptr;
        bresp_d    = RESP_OKAY;
        state_d    = ST_RESP;
      end else begin
        // Context is released only once the consumer takes the descriptor
        upd_en    = 1'b0;
        cpl_tag_d = cur_hdr.tag;
        cpl_len_d = cur_ptr;
        cpl_hdr_d = cur_hdr;
        state_d   = ST_CPL;
      end
    end

    ptr_d = cur_ptr;
    cnt_d = cur_cnt;
  end

  // Handshake outputs decoded from registered state
  always_comb begin
    axi_awready = (state_q == ST_IDLE) && init_q;
    axi_wready  = (state_q == ST_HDR) || (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);
    axi_bvalid  = (state_q == ST_RESP);
    cpl_valid   = (state_q == ST_CPL);
  end

  // Datapath registers, including the registered SRAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      awlen_q      <= '0;
      cnt_q        <= '0;
      hdr_q        <= '0;
      ptr_q        <= '0;
      bresp_q      <= RESP_OKAY;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      cpl_tag_q    <= '0;
      cpl_len_q    <= '0;
      cpl_hdr_q    <= '0;
      sram_wen_q   <= 1'b0;
      sram_waddr_q <= '0;
      sram_wdata_q <= '0;
    end else begin
      awlen_q      <= awlen_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      ptr_q        <= ptr_d;
      bresp_q      <= bresp_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      cpl_tag_q    <= cpl_tag_d;
      cpl_len_q    <= cpl_len_d;
      cpl_hdr_q    <= cpl_hdr_d;
      sram_wen_q   <= sram_wen_d;
      sram_waddr_q <= sram_waddr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign axi_bresp  = bresp_q;
  assign sram_wen   = sram_wen_q;
  assign sram_waddr = sram_waddr_q;
  assign sram_wdata = sram_wdata_q;
  assign cpl_tag    = cpl_tag_q;
  assign cpl_len    = cpl_len_q;
  assign cpl_header = cpl_hdr_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;

endmodule

// File: doc/pcie_msg_assembler.md
# pcie_msg_assembler

Parametrised successor to the single-channel PCIe message receiver. Accepts fragmented message writes on a single-beat-header AXI write slave and assembles payload in place in an SRAM region per message tag. Supports a configurable tag count, data width and maximum message size. Adds protocol-error detection with SLVERR responses and a backpressured completion descriptor for the downstream message consumer.

## Interface
- DATA_W, 256, AXI/SRAM data width; must be ≥128.
- NUM_TAGS, 15, number of assembly contexts (tags 0..NUM_TAGS-1); ≤16.
- MSG_BEATS_LOG2, 6, log2 of maximum payload beats per assembled message; the per-tag SRAM region size.
- LEN_W, 8, width of axi_awlen.
- SRAM_AW = 4 + MSG_BEATS_LOG2 (derived). SRAM address = {tag[3:0], ptr}.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- axi_awvalid / axi_awready  in/out  1  address handshake.
- axi_awaddr  in  64  accepted, ignored (placement is tag-based).
- axi_awlen  in  LEN_W  beats-1 of this fragment, header beat included.
- axi_wvalid / axi_wready  in/out  1  data handshake.
- axi_wdata  in  DATA_W  data; first beat carries the header in [127:0].
- axi_wlast  in  1  last beat.
- axi_bvalid / axi_bready  out/in  1  response handshake.
- axi_bresp  out  2  00 OKAY, 10 SLVERR.
- sram_wen  out  1  write strobe.
- sram_waddr  out  SRAM_AW  write address.
- sram_wdata  out  DATA_W  write data.
- cpl_valid / cpl_ready  out/in  1  completion descriptor handshake.
- cpl_tag  out  4  completed tag.
- cpl_len  out  MSG_BEATS_LOG2+1  payload beats in the message (0 allowed).
- cpl_header  out  128  header of the L or SG fragment.
- err_valid  out  1  one-cycle pulse per aborted fragment.
- err_code  out  3  error code, valid with err_valid.

## Operation
- Header fields: [127:126] frag type (S=10, M=00, L=01, SG=11); [125:124] PKT_SN; [123:120] TAG; [119:0] TLP.
- Per-tag context: active bit, expected SN (2 bits), write pointer (MSG_BEATS_LOG2+1 bits).
- FSM states:
  - IDLE: awready=1; on AW handshake latch awlen, go to HDR.
  - HDR: wready=1; decode the first beat, then check:
    - TAG ≥ NUM_TAGS → err 1.
    - S with SN≠0 → err 2.
    - M or L on an inactive tag, or SN≠expected → err 3.
  - S or SG on a tag: reset ptr=0 (an active context is silently restarted); S sets active=1, expected SN=1.
  - PAYLOAD: wready=1; each beat writes SRAM at {tag, ptr}, then ptr++.
    - ptr reaching 2^MSG_BEATS_LOG2 with more beats pending → err 4; remaining beats are drained.
    - At wlast: beat count ≠ awlen+1 → err 5.
    - M or S: expected SN += 1 (mod 4, wraps 3→0), go to RESP OKAY.
    - L or SG: go to CPL.
  - DRAIN: wready=1; discard beats until wlast, then go to RESP SLVERR.
  - CPL: hold cpl_valid with {tag, ptr, header} until cpl_ready; then clear active and go to RESP OKAY.
  - RESP: hold bvalid and bresp until bready, then go to IDLE.
- Error handling: any error pulses err_valid and clears the tag's active bit (if TAG is in range). The header beat itself is discarded. A header beat with wlast detected as an error goes straight to RESP.
- Header handling: header beats are never written to SRAM. An M fragment with only the header beat is legal and appends nothing.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=00, sram_wen=0, sram_waddr=0, sram_wdata=0, cpl_valid=0, cpl_tag=0, cpl_len=0, cpl_header=0, err_valid=0, err_code=0; all contexts inactive; FSM in IDLE.
- awready and wready are decoded from registered state. awready rises the cycle after reset deasserts.
- SRAM write is registered: sram_wen/addr/data are valid one cycle after the W handshake. No SRAM backpressure.
- Throughput: one beat per cycle. Minimum fragment turnaround is AW, beats, then B, plus 1 IDLE cycle.
- Completion: cpl_valid rises the cycle after the wlast handshake, at which point the last payload write is already issued. bvalid follows cpl acceptance by 1 cycle.
- cpl_* and bresp are stable while valid and not yet accepted.
- Reset mid-burst: everything is abandoned with no B response; the SRAM contents are undefined to the consumer.

## Structure
- Package pcie_msg_pkg: frag-type constants, header field offsets, err_code enum (1 BAD_TAG, 2 BAD_S_SN, 3 SEQ, 4 OVERFLOW, 5 LEN_MISMATCH), FSM state encoding.
- Sub-module pcie_msg_ctx_table: per-tag active, expected-SN and ptr registers, with one read port (tag) and one update port.

## Test plan
- SG on tag 2, awlen=3 → 3 SRAM writes at 0x80..0x82; cpl{tag=2, len=3}; OKAY.
- S(SN0, 2 payload) + M(SN1, 1) + M(SN2, 0) + L(SN3, 2) on tag 5 → writes at 0x140..0x144; cpl len=5 with the L header; four OKAY responses.
- M with SN2 after S on tag 1 → err 3, SLVERR, no SRAM write; a following L on tag 1 also gives err 3.
- TAG=15 with NUM_TAGS=15 → err 1, all beats drained, SLVERR.
- MSG_BEATS_LOG2=2: S with 6 payload beats → 4 writes, err 4, SLVERR, tag inactive.
- wlast after 2 beats with awlen=3 → err 5. Separately: hold cpl_ready=0 for 10 cycles → cpl stable and bvalid low until acceptance. Separately: assert rst mid-payload → all outputs at reset values next cycle.
